// File: rtl/max7219_chain_ctrl.sv
// MAX7219 daisy-chain driver: broadcasts the power-up configuration, then refreshes
// all 8 rows of every device from a synchronous-read frame buffer.
module max7219_chain_ctrl #(
    parameter int N_DEV        = 4,
    parameter int CLK_DIV      = 4,
    parameter int SCAN_LIMIT   = 7,
    parameter int AUTO_REFRESH = 1,
    parameter int AW           = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    intensity,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy,
    output logic          frame_done,
    output logic          max7219_din,
    output logic          max7219_ncs,
    output logic          max7219_clk
);
    localparam int DEV_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] SCLK_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DEV_W-1:0] DEV_LAST  = DEV_W'(N_DEV - 1);

    typedef enum logic [2:0] {
        S_INIT_LOAD, S_FETCH, S_WAIT, S_SHIFT, S_GAP, S_IDLE, S_INT_LOAD
    } state_t;
    typedef enum logic [1:0] {K_INIT, K_INT, K_ROW} kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [2:0]       init_idx_q, init_idx_d;
    logic [DEV_W-1:0] dev_q, dev_d;
    logic [2:0]       row_q, row_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      sr_q, sr_d;
    logic [3:0]       int_sent_q, int_sent_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             din_q, din_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic             load_bcast, fetch_row;
    logic [15:0]      bcast_word;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
        case (idx)
            3'd0:    return 16'h0C01;
            3'd1:    return {8'h0B, 8'(SCAN_LIMIT)};
            3'd2:    return {12'h0A0, inten};
            3'd3:    return 16'h0900;
            default: return 16'h0F00;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [DEV_W-1:0] dev, input logic [2:0] row);
        return (AW'(dev) << 3) | AW'(row);
    endfunction

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d      = state_q;
        kind_d       = kind_q;
        init_idx_d   = init_idx_q;
        dev_d        = dev_q;
        row_d        = row_q;
        bit_d        = bit_q;
        div_d        = div_q;
        sr_d         = sr_q;
        int_sent_d   = int_sent_q;
        rd_addr_d    = rd_addr_q;
        din_d        = din_q;
        ncs_d        = ncs_q;
        sclk_d       = sclk_q;
        frame_done_d = 1'b0;
        load_bcast   = 1'b0;
        fetch_row    = 1'b0;
        bcast_word   = 16'h0000;

        case (state_q)
            S_INIT_LOAD: begin
                load_bcast = 1'b1;
                bcast_word = init_word(init_idx_q, intensity);
                kind_d     = K_INIT;
            end
            S_INT_LOAD: begin
                load_bcast = 1'b1;
                bcast_word = {12'h0A0, intensity};
                kind_d     = K_INT;
            end
            S_IDLE: begin
                if (AUTO_REFRESH != 0 || start) begin
                    if (intensity != int_sent_q) begin
                        state_d = S_INT_LOAD;
                    end else begin
                        fetch_row = 1'b1;
                        row_d     = 3'd0;
                        kind_d    = K_ROW;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                sr_d    = {4'h0, {1'b0, row_q} + 4'd1, rd_data};
                din_d   = 1'b0;
                div_d   = '0;
                bit_d   = 4'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == SCLK_RISE) sclk_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    // Rotating rather than shifting restores the word after 16 bits,
                    // so a broadcast simply keeps going for the next device.
                    div_d  = '0;
                    sclk_d = 1'b0;
                    sr_d   = {sr_q[14:0], sr_q[15]};
                    din_d  = sr_q[14];
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        if (dev_q != '0) begin
                            dev_d = dev_q - 1'b1;
                            if (kind_q == K_ROW) begin
                                din_d     = 1'b0;
                                rd_addr_d = addr_of(dev_q - 1'b1, row_q);
                                state_d   = S_FETCH;
                            end
                        end else begin
                            din_d   = 1'b0;
                            ncs_d   = 1'b1;
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    case (kind_q)
                        K_INIT: begin
                            if (init_idx_q == 3'd4) begin
                                state_d = S_IDLE;
                            end else begin
                                init_idx_d = init_idx_q + 3'd1;
                                load_bcast = 1'b1;
                                bcast_word = init_word(init_idx_q + 3'd1, intensity);
                            end
                        end
                        K_INT: begin
                            fetch_row = 1'b1;
                            row_d     = 3'd0;
                            kind_d    = K_ROW;
                        end
                        default: begin
                            if (row_q == 3'd7) begin
                                row_d        = 3'd0;
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                row_d     = row_q + 3'd1;
                                fetch_row = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_INIT_LOAD;
        endcase

        if (load_bcast) begin
            sr_d    = bcast_word;
            din_d   = bcast_word[15];
            ncs_d   = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = 4'd0;
            dev_d   = DEV_LAST;
            state_d = S_SHIFT;
            if (bcast_word[15:8] == 8'h0A) int_sent_d = bcast_word[3:0];
        end
        if (fetch_row) begin
            ncs_d     = 1'b0;
            dev_d     = DEV_LAST;
            rd_addr_d = addr_of(DEV_LAST, row_d);
            state_d   = S_FETCH;
        end
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT_LOAD;
            kind_q       <= K_INIT;
            init_idx_q   <= 3'd0;
            dev_q        <= '0;
            row_q        <= 3'd0;
            bit_q        <= 4'd0;
            div_q        <= '0;
            sr_q         <= 16'h0000;
            int_sent_q   <= 4'd0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            din_q        <= 1'b0;
            ncs_q        <= 1'b1;
            sclk_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            init_idx_q   <= init_idx_d;
            dev_q        <= dev_d;
            row_q        <= row_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            sr_q         <= sr_d;
            int_sent_q   <= int_sent_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            din_q        <= din_d;
            ncs_q        <= ncs_d;
            sclk_q       <= sclk_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign max7219_din = din_q;
    assign max7219_ncs = ncs_q;
    assign max7219_clk = sclk_q;
endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Bench for max7219_chain_ctrl: decodes the serial line into transactions and
// compares them with a word-level model of the init sequence and frame refresh.
module tb_max7219_chain_ctrl;
    localparam int N_DEV = 2, CLK_DIV = 2, SCAN_LIMIT = 7, AW = 4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0] intensity = 4'd5;
    logic [AW-1:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic busy, frame_done, max7219_din, max7219_ncs, max7219_clk;

    max7219_chain_ctrl #(
        .N_DEV(N_DEV), .CLK_DIV(CLK_DIV), .SCAN_LIMIT(SCAN_LIMIT), .AUTO_REFRESH(0), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .intensity(intensity),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
        .max7219_din(max7219_din), .max7219_ncs(max7219_ncs), .max7219_clk(max7219_clk)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct { logic [127:0] data; int nbits; int low_len; int gap; } txn_t;
    typedef struct { logic [127:0] data; int nbits; bit bcast; } exp_t;
    txn_t txn_q[$];
    exp_t exp_q[$];
    logic [AW-1:0] addr_q[$];

    int n_checks = 0, n_err = 0;
    logic [127:0] mon_data = '0;
    int mon_nbits = 0, mon_low = 0, mon_high = -1, cur_gap = -1;
    bit mon_in = 1'b0;
    logic ncs_p = 1'b1, sclk_p = 1'b0;
    logic [AW-1:0] addr_p = '0;
    int sclk_bad = 0, fd_cycles = 0, fd_dist = 0, since_rise = 0;
    logic [3:0] model_int_sent = 4'd0;

    // Serial-line monitor, sampling on the falling system-clock edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_in   = 1'b0;
            mon_high = -1;
        end else begin
            if (max7219_ncs && ncs_p && max7219_clk !== sclk_p) sclk_bad++;
            if (!max7219_ncs) begin
                if (ncs_p) begin
                    mon_in = 1'b1; mon_data = '0; mon_nbits = 0; mon_low = 0; cur_gap = mon_high;
                end
                mon_low++;
                if (max7219_clk && !sclk_p) begin
                    mon_data = {mon_data[126:0], max7219_din};
                    mon_nbits++;
                end
            end else begin
                if (!ncs_p && mon_in) begin
                    txn_q.push_back('{mon_data, mon_nbits, mon_low, cur_gap});
                    mon_in = 1'b0; mon_high = 0; since_rise = 0;
                end
                if (mon_high >= 0) mon_high++;
                since_rise++;
            end
            if (frame_done) begin fd_cycles++; fd_dist = since_rise; end
            if (rd_addr !== addr_p) addr_q.push_back(rd_addr);
        end
        ncs_p = max7219_ncs; sclk_p = max7219_clk; addr_p = rd_addr;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_bcast(input logic [15:0] w);
        exp_t e;
        e.data = '0;
        for (int d = 0; d < N_DEV; d++) e.data = (e.data << 16) | 128'(w);
        e.nbits = 16 * N_DEV;
        e.bcast = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_init(input logic [3:0] inten);
        push_bcast(16'h0C01);
        push_bcast(16'h0B00 + 16'(SCAN_LIMIT));
        push_bcast(16'h0A00 + 16'(inten));
        push_bcast(16'h0900);
        push_bcast(16'h0F00);
        model_int_sent = inten;
    endtask

    task automatic push_frame(input logic [3:0] inten);
        exp_t e;
        if (inten != model_int_sent) begin
            push_bcast(16'h0A00 + 16'(inten));
            model_int_sent = inten;
        end
        for (int r = 0; r < 8; r++) begin
            e.data = '0;
            for (int d = N_DEV - 1; d >= 0; d--)
                e.data = (e.data << 16) | 128'((r + 1) * 256 + int'(mem[d * 8 + r]));
            e.nbits = 16 * N_DEV;
            e.bcast = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_txns(input string tag);
        int n;
        txn_t t;
        exp_t e;
        n = exp_q.size();
        for (int i = 0; i < n * 600 + 600 && txn_q.size() < n; i++) tick();
        check({tag, "_count"}, 128'(txn_q.size()), 128'(n));
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (txn_q.size() == 0) continue;
            t = txn_q.pop_front();
            check($sformatf("%s[%0d].data", tag, i), t.data, e.data);
            check($sformatf("%s[%0d].bits", tag, i), 128'(t.nbits), 128'(e.nbits));
            if (e.bcast)
                check($sformatf("%s[%0d].low_len", tag, i), 128'(t.low_len), 128'(e.nbits * 2 * CLK_DIV));
            if (i > 0)
                check($sformatf("%s[%0d].gap", tag, i), 128'(t.gap), 128'(2 * CLK_DIV));
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && busy !== 1'b0; i++) tick();
        check(tag, busy, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        bit found;
        fill_mem();
        repeat (3) tick();
        check("rst_ncs", max7219_ncs, 1'b1);
        check("rst_sclk", max7219_clk, 1'b0);
        check("rst_din", max7219_din, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_rd_addr", rd_addr, '0);
        reset = 1'b0;
        push_init(intensity);
        compare_txns("init");
        wait_idle("idle_after_init");

        // Frame 1: known row-0 pattern, extra start pulses while busy.
        fill_mem();
        mem[8] = 8'hAA;
        mem[0] = 8'h55;
        addr_q.delete();
        fd_cycles = 0;
        push_frame(intensity);
        pulse_start();
        repeat (20) tick();
        check("busy_in_frame", busy, 1'b1);
        pulse_start();
        repeat (300) tick();
        check("busy_in_frame2", busy, 1'b1);
        pulse_start();
        compare_txns("frame1");
        wait_idle("idle_after_frame1");
        check("frame_done_cycles", 128'(fd_cycles), 128'(1));
        check("frame_done_dist", 128'(fd_dist), 128'(2 * CLK_DIV + 1));
        check("addr_count", 128'(addr_q.size()), 128'(8 * N_DEV));
        for (int r = 0; r < 8; r++)
            for (int d = N_DEV - 1; d >= 0; d--)
                if (addr_q.size() > 0) check($sformatf("addr_r%0d_d%0d", r, d), addr_q.pop_front(), 128'(d * 8 + r));
        repeat (300) tick();
        check("no_extra_busy", busy, 1'b0);
        check("no_extra_txn", 128'(txn_q.size()), 128'(0));

        // Frame 2: intensity changes mid-frame, frame itself unaffected.
        fill_mem();
        push_frame(intensity);
        pulse_start();
        repeat (300) tick();
        intensity = 4'd12;
        compare_txns("frame2");
        wait_idle("idle_after_frame2");

        // Frame 3 carries the 0x0A0C broadcast; frame 4 does not.
        fill_mem();
        push_frame(intensity);
        pulse_start();
        compare_txns("frame3");
        wait_idle("idle_after_frame3");
        fill_mem();
        push_frame(intensity);
        pulse_start();
        compare_txns("frame4");
        wait_idle("idle_after_frame4");

        for (int k = 0; k < 3; k++) begin
            intensity = 4'($urandom);
            fill_mem();
            push_frame(intensity);
            pulse_start();
            compare_txns($sformatf("rand%0d", k));
            wait_idle($sformatf("idle_after_rand%0d", k));
        end

        // Reset in the middle of a row transaction.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            found = mon_in && mon_nbits == 9;
        end
        check("reach_bit9", found, 1'b1);
        reset = 1'b1;
        tick();
        check("midrst_ncs", max7219_ncs, 1'b1);
        check("midrst_sclk", max7219_clk, 1'b0);
        check("midrst_din", max7219_din, 1'b0);
        check("midrst_busy", busy, 1'b1);
        intensity = 4'($urandom);
        tick();
        txn_q.delete();
        exp_q.delete();
        reset = 1'b0;
        push_init(intensity);
        compare_txns("reinit");
        wait_idle("idle_after_reinit");

        fill_mem();
        push_frame(intensity);
        pulse_start();
        compare_txns("frame_last");
        wait_idle("idle_after_last");
        check("sclk_edges_ncs_high", 128'(sclk_bad), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
